prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Program-flow controller that replaces the free-running program counter ahead of the program ROM.
- Holds the program address and applies the ICU-decoded flow op each cycle: next, jump, branch on the zed flag, call, return or halt.
- Keeps a small return-address stack.
- Exposes run/halt/fault status so the ICU and the output selectors can be gated.

Parameters:
- N, 2, program address width; matches the ROM address width.
- DEPTH, 2, return-stack entries (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- go  input  1  start request; sampled in IDLE.
- op  input  3  flow op from ICU: 0 NEXT, 1 JMP, 2 JZ, 3 JNZ, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as NEXT).
- target  input  N  branch/call destination.
- zed  input  1  zero flag from the datapath; sampled in the same cycle as op.
- addr  output  N  registered program address to the ROM.
- running  output  1  high in RUN; ICU write enables are qualified with it.
- halted  output  1  high in HALT.
- fault  output  1  high in FAULT (stack error).
- depth  output  $clog2(DEPTH+1)  current stack occupancy.

Behaviour:
- Reset: clk edge with rst=0 → state IDLE, addr=0, stack pointer=0, running=0, halted=0, fault=0, depth=0. Stack contents don't care. Reset dominates all inputs, including mid-CALL/RET.
- FSM states: IDLE, RUN, HALT, FAULT. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: addr holds 0. go=1 → RUN next cycle; op ignored.
- RUN: one op per cycle; addr updates on the same edge (1-cycle latency from op/target to addr):
  - NEXT / reserved: addr ← addr+1, wrapping mod 2^N (2^N−1 → 0).
  - JMP: addr ← target.
  - JZ: addr ← target if zed=1, else addr+1.
  - JNZ: addr ← target if zed=0, else addr+1.
  - CALL: push addr+1 (wrapped), then addr ← target; depth+1.
  - RET: addr ← top-of-stack, pop; depth−1.
  - HALT: addr holds; state → HALT.
- HALT: addr frozen. go=1 → RUN with addr unchanged, so execution resumes at the halt instruction's address. go is a level; the ICU is expected to deassert it or advance past the HALT.
- Stack: LIFO. Push and pop never occur in the same cycle; op is single-valued.
- Stack boundary, CALL at depth=DEPTH or RET at depth=0: behaviour selected by the optional feature.
- FAULT: addr frozen, stack frozen. Exited only by reset; go is ignored.
- running, halted and fault are mutually exclusive, one-hot with IDLE implied when all are low.

Optional Feature:
- Macro: SEQ_STACK_GUARD_EN.
- Defined:
  - CALL at depth=DEPTH → no push, addr unchanged, state → FAULT.
  - RET at depth=0 → no pop, addr unchanged, state → FAULT.
- Undefined:
  - FAULT is unreachable and fault is tied 0.
  - Stack pointer wraps mod DEPTH: overflow overwrites the oldest entry and depth saturates at DEPTH.
  - RET on an empty stack loads entry 0 and depth stays 0.

Decomposition:
- Shared package (seq_pkg):
  - op encodings OP_NEXT … OP_HALT.
  - state encodings ST_IDLE, ST_RUN, ST_HALT, ST_FAULT.
  - address-width default.
- Sub-module ret_stack, parameterised (N, DEPTH): push, pop, data in, top, depth. Its guard/wrap behaviour is controlled by the same macro.
- FSM and next-address mux stay in prog_sequencer.

Test Plan:
- Reset, go, then NEXT ×5 with N=2: reset gives addr=0, IDLE. After go, addr sequence 0,1,2,3,0,1 (wrap); running=1 throughout.
- Conditional branch: JZ target=2 with zed=1 → addr=2 next cycle. Then JNZ target=0 with zed=1 → addr=3 (fall-through).
- Call/return: at addr=1, CALL target=3 → addr=3, depth=1. Then RET → addr=2, depth=0.
- Guarded overflow, macro defined, DEPTH=2: three CALLs → third leaves addr unchanged and fault=1, depth=2. Then go=1 → no change. Then rst=0 for one edge → IDLE, addr=0, fault=0.
- Unguarded underflow, macro undefined: RET at depth=0 → no fault, depth=0, addr=stack entry 0.
- Halt/resume and mid-op reset: HALT at addr=2 → halted=1, addr holds 2 for 3 cycles. go → running=1 with addr=2 first. Assert rst on the same edge as a CALL → addr=0, depth=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared flow-op and state encodings for prog_sequencer and its return stack.
package seq_pkg;

  localparam int ADDR_W_DEFAULT = 2;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_JZ   = 3'd2,
    OP_JNZ  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HALT = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } st_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. With SEQ_STACK_GUARD_EN, pushes when full and pops when empty
// are ignored; without it the write pointer wraps, overwriting the oldest entry.
module ret_stack
  import seq_pkg::*;
#(
  parameter int N     = ADDR_W_DEFAULT,
  parameter int DEPTH = 2,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  top,
  output logic [DW-1:0] depth
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [IW-1:0] wp_q, wp_d, wp_inc, wp_dec;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          full, empty, push_ok, pop_ok;

  assign full   = (cnt_q == DW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign wp_inc = (wp_q == IW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
  assign wp_dec = (wp_q == '0) ? IW'(DEPTH - 1) : wp_q - 1'b1;

`ifdef SEQ_STACK_GUARD_EN
  assign push_ok = push && !full;
`else
  assign push_ok = push;
`endif
  assign pop_ok  = pop && !empty;

  // An empty stack presents entry 0, which is what an unguarded underflow returns.
  assign top   = empty ? mem_q[0] : mem_q[wp_dec];
  assign depth = cnt_q;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      wp_d  = wp_inc;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
    end else if (pop_ok) begin
      wp_d  = wp_dec;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program-flow controller: holds the ROM address and applies one flow op per cycle.
// SEQ_STACK_GUARD_EN turns stack overflow/underflow into a sticky FAULT state.
//   state    | meaning
//   ST_IDLE  | after reset, addr=0, waiting for go
//   ST_RUN   | executing one op per cycle
//   ST_HALT  | addr frozen, go resumes at the same address
//   ST_FAULT | stack error, frozen until reset
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int N     = ADDR_W_DEFAULT,
  parameter int DEPTH = 2,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [2:0]    op,
  input  logic [N-1:0]  target,
  input  logic          zed,
  output logic [N-1:0]  addr,
  output logic          running,
  output logic          halted,
  output logic          fault,
  output logic [DW-1:0] depth
);

  st_e          state_q, state_d;
  logic [N-1:0] addr_q, addr_d, addr_inc;
  logic         push, pop;
  logic [N-1:0] stk_top;
  logic [DW-1:0] stk_depth;

  ret_stack #(.N(N), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .top   (stk_top),
    .depth (stk_depth)
  );

  assign addr_inc = addr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (go) state_d = ST_RUN;
      end
      ST_RUN: begin
        case (op)
          OP_JMP:  addr_d = target;
          OP_JZ:   addr_d = zed ? target : addr_inc;
          OP_JNZ:  addr_d = zed ? addr_inc : target;
          OP_CALL: begin
`ifdef SEQ_STACK_GUARD_EN
            if (stk_depth == DW'(DEPTH)) begin
              state_d = ST_FAULT;
            end else begin
              push   = 1'b1;
              addr_d = target;
            end
`else
            push   = 1'b1;
            addr_d = target;
`endif
          end
          OP_RET: begin
`ifdef SEQ_STACK_GUARD_EN
            if (stk_depth == '0) begin
              state_d = ST_FAULT;
            end else begin
              pop    = 1'b1;
              addr_d = stk_top;
            end
`else
            pop    = 1'b1;
            addr_d = stk_top;
`endif
          end
          OP_HALT: state_d = ST_HALT;
          default: addr_d = addr_inc;
        endcase
      end
      ST_HALT: if (go) state_d = ST_RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign addr    = addr_q;
  assign running = (state_q == ST_RUN);
  assign halted  = (state_q == ST_HALT);
`ifdef SEQ_STACK_GUARD_EN
  assign fault   = (state_q == ST_FAULT);
`else
  assign fault   = 1'b0;
`endif
  assign depth   = stk_depth;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a queue-based reference model checked every cycle.
// Builds with or without SEQ_STACK_GUARD_EN; literal expectations follow the build.
module tb_prog_sequencer;

  localparam int N     = 2;
  localparam int DEPTH = 2;
  localparam int DW    = $clog2(DEPTH + 1);
`ifdef SEQ_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [N-1:0]  target = '0;
  logic          zed = 1'b0;
  logic [N-1:0]  addr;
  logic          running, halted, fault;
  logic [DW-1:0] depth;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  prog_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .target(target), .zed(zed),
    .addr(addr), .running(running), .halted(halted), .fault(fault), .depth(depth)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 run, 2 halt, 3 fault; queue is the logical stack,
  // slot array + write slot only used to know what "entry 0" holds on underflow.
  int m_st = 0;
  int m_addr = 0;
  int q[$];
  int m_mem[DEPTH];
  int m_wp = 0;
  localparam int AMASK = (1 << N) - 1;

  always @(posedge clk) begin
    int nxt;
    nxt = (m_addr + 1) & AMASK;
    if (!rst) begin
      m_st = 0; m_addr = 0; q.delete(); m_wp = 0;
    end else begin
      case (m_st)
        0: begin m_addr = 0; if (go) m_st = 1; end
        1: case (int'(op))
          1: m_addr = int'(target);
          2: m_addr = zed ? int'(target) : nxt;
          3: m_addr = zed ? nxt : int'(target);
          4: if (GUARD && q.size() == DEPTH) m_st = 3;
             else begin
               m_mem[m_wp] = nxt;
               m_wp = (m_wp + 1) % DEPTH;
               q.push_back(nxt);
               if (q.size() > DEPTH) void'(q.pop_front());
               m_addr = int'(target);
             end
          5: if (q.size() == 0) begin
               if (GUARD) m_st = 3; else m_addr = m_mem[0];
             end else begin
               m_addr = q.pop_back();
               m_wp = (m_wp + DEPTH - 1) % DEPTH;
             end
          6: m_st = 2;
          default: m_addr = nxt;
        endcase
        2: if (go) m_st = 1;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_addr", int'(addr), m_addr);
      chk("model_running", int'(running), int'(m_st == 1));
      chk("model_halted", int'(halted), int'(m_st == 2));
      chk("model_fault", int'(fault), int'(m_st == 3));
      chk("model_depth", int'(depth), q.size());
    end
  end

  task automatic step(input logic r, input logic g, input int o, input int t, input logic z);
    rst = r; go = g; op = 3'(o); target = N'(t); zed = z;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    do_reset();
    chk("reset_addr", int'(addr), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_depth", int'(depth), 0);

    // go with a JMP op present: IDLE ignores op
    step(1'b1, 1'b1, 1, 3, 1'b0);
    chk("go_addr", int'(addr), 0);
    chk("go_running", int'(running), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      chk("next_addr", int'(addr), (i + 1) % 4);
    end

    step(1'b1, 1'b0, 2, 2, 1'b1);
    chk("jz_taken", int'(addr), 2);
    step(1'b1, 1'b0, 3, 0, 1'b1);
    chk("jnz_fall", int'(addr), 3);
    step(1'b1, 1'b0, 1, 1, 1'b0);
    chk("jmp", int'(addr), 1);
    step(1'b1, 1'b0, 4, 3, 1'b0);
    chk("call_addr", int'(addr), 3);
    chk("call_depth", int'(depth), 1);
    step(1'b1, 1'b0, 5, 0, 1'b0);
    chk("ret_addr", int'(addr), 2);
    chk("ret_depth", int'(depth), 0);
    step(1'b1, 1'b0, 2, 0, 1'b0);
    chk("jz_fall", int'(addr), 3);
    step(1'b1, 1'b0, 3, 1, 1'b0);
    chk("jnz_taken", int'(addr), 1);
    step(1'b1, 1'b0, 7, 0, 1'b0);
    chk("reserved_next", int'(addr), 2);
    step(1'b1, 1'b0, 1, 0, 1'b0);
    step(1'b1, 1'b0, 5, 0, 1'b0);
    chk("under_addr", int'(addr), GUARD ? 0 : 2);
    chk("under_fault", int'(fault), GUARD ? 1 : 0);
    chk("under_depth", int'(depth), 0);

    // overflow
    do_reset();
    step(1'b1, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b0, 4, 3, 1'b0);
    step(1'b1, 1'b0, 4, 1, 1'b0);
    chk("call2_depth", int'(depth), 2);
    step(1'b1, 1'b0, 4, 2, 1'b0);
    chk("over_addr", int'(addr), GUARD ? 1 : 2);
    chk("over_fault", int'(fault), GUARD ? 1 : 0);
    chk("over_depth", int'(depth), 2);
    if (GUARD) begin
      step(1'b1, 1'b1, 1, 0, 1'b0);
      chk("fault_go_addr", int'(addr), 1);
      chk("fault_go_fault", int'(fault), 1);
      do_reset();
      chk("fault_rst_addr", int'(addr), 0);
      chk("fault_rst_fault", int'(fault), 0);
    end else begin
      step(1'b1, 1'b0, 5, 0, 1'b0);
      chk("wrap_ret1", int'(addr), 2);
      step(1'b1, 1'b0, 5, 0, 1'b0);
      chk("wrap_ret2", int'(addr), 0);
      step(1'b1, 1'b0, 5, 0, 1'b0);
      chk("wrap_ret_empty", int'(addr), 2);
      chk("wrap_depth", int'(depth), 0);
    end

    // halt / resume / reset during CALL
    do_reset();
    step(1'b1, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1, 2, 1'b0);
    step(1'b1, 1'b0, 6, 0, 1'b0);
    chk("halt_halted", int'(halted), 1);
    chk("halt_addr", int'(addr), 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1, 0, 1'b0);
      chk("halt_hold", int'(addr), 2);
    end
    step(1'b1, 1'b1, 1, 0, 1'b0);
    chk("resume_running", int'(running), 1);
    chk("resume_addr", int'(addr), 2);
    step(1'b1, 1'b0, 4, 3, 1'b0);
    chk("pre_rst_depth", int'(depth), 1);
    step(1'b0, 1'b0, 4, 1, 1'b0);
    chk("midcall_rst_addr", int'(addr), 0);
    chk("midcall_rst_depth", int'(depth), 0);
    chk("midcall_rst_running", int'(running), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
